// File: rtl/branch_predictor.sv
// Gshare branch predictor: a PHT of 2-bit saturating counters indexed by PC XOR global history.
// The registered decode-stage prediction travels with the GHR snapshot used to make it.
module branch_predictor #(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pcF,
  input  logic             stallD,
  input  logic             flushD,
  output logic             predict_takeD,
  input  logic             update_en,
  input  logic [31:0]      update_pc,
  input  logic [IDX_W-1:0] update_ghr,
  input  logic             actual_taken,
  input  logic             pred_taken,
  output logic [IDX_W-1:0] ghrD,
  output logic             mispredict,
  output logic [31:0]      br_cnt,
  output logic [31:0]      mis_cnt
);
  localparam int ENTRIES = 1 << IDX_W;

  logic [1:0]       pht [ENTRIES];
  logic [IDX_W-1:0] ghr;
  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] update_idx;

  assign lookup_idx = pcF[IDX_W+1:2] ^ ghr;
  assign update_idx = update_pc[IDX_W+1:2] ^ update_ghr;
  assign mispredict = update_en & (pred_taken != actual_taken);

  // Each counter is its own register so reset can preload every entry to weakly not-taken.
  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_pht
      always_ff @(posedge clk) begin
        if (rst) begin
          pht[gi] <= 2'b01;
        end else if (update_en && (update_idx == IDX_W'(gi))) begin
          if (actual_taken && (pht[gi] != 2'b11)) begin
            pht[gi] <= pht[gi] + 2'b01;
          end else if (!actual_taken && (pht[gi] != 2'b00)) begin
            pht[gi] <= pht[gi] - 2'b01;
          end
        end
      end
    end
  endgenerate

  // Lookup samples the pre-update PHT and GHR, giving read-before-write on a same-cycle hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr           <= '0;
      predict_takeD <= 1'b0;
      ghrD          <= '0;
      br_cnt        <= '0;
      mis_cnt       <= '0;
    end else begin
      if (update_en) begin
        ghr    <= {ghr[IDX_W-2:0], actual_taken};
        br_cnt <= br_cnt + 32'd1;
        if (mispredict) begin
          mis_cnt <= mis_cnt + 32'd1;
        end
      end
      if (flushD) begin
        predict_takeD <= 1'b0;
        ghrD          <= '0;
      end else if (!stallD) begin
        predict_takeD <= pht[lookup_idx][1];
        ghrD          <= ghr;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random traffic,
// compared each cycle against an array-based behavioural model.
module tb_branch_predictor;
  localparam int IDX_W = 6;
  localparam int ENTRIES = 1 << IDX_W;
  localparam int MASK = ENTRIES - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      pcF = '0;
  logic             stallD = 1'b0;
  logic             flushD = 1'b0;
  logic             predict_takeD;
  logic             update_en = 1'b0;
  logic [31:0]      update_pc = '0;
  logic [IDX_W-1:0] update_ghr = '0;
  logic             actual_taken = 1'b0;
  logic             pred_taken = 1'b0;
  logic [IDX_W-1:0] ghrD;
  logic             mispredict;
  logic [31:0]      br_cnt;
  logic [31:0]      mis_cnt;

  branch_predictor #(.IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .pcF(pcF), .stallD(stallD), .flushD(flushD),
    .predict_takeD(predict_takeD), .update_en(update_en), .update_pc(update_pc),
    .update_ghr(update_ghr), .actual_taken(actual_taken), .pred_taken(pred_taken),
    .ghrD(ghrD), .mispredict(mispredict), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Behavioural model state: counters as integers 0..3, history as an integer.
  int          pht_m [ENTRIES];
  int          ghr_m;
  bit          pred_m;
  int          ghrd_m;
  logic [31:0] br_m;
  logic [31:0] mis_m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_step(input bit r, input logic [31:0] pc, input bit st, input bit fl,
                            input bit ue, input logic [31:0] up, input int ug,
                            input bit act, input bit pt);
    int li, ui;
    if (r) begin
      for (int i = 0; i < ENTRIES; i++) pht_m[i] = 1;
      ghr_m = 0; pred_m = 0; ghrd_m = 0; br_m = 0; mis_m = 0;
      return;
    end
    li = ((pc >> 2) ^ ghr_m) & MASK;
    ui = ((up >> 2) ^ ug) & MASK;
    if (fl) begin
      pred_m = 0; ghrd_m = 0;
    end else if (!st) begin
      pred_m = (pht_m[li] >= 2); ghrd_m = ghr_m;
    end
    if (ue) begin
      if (act) pht_m[ui] = (pht_m[ui] == 3) ? 3 : pht_m[ui] + 1;
      else     pht_m[ui] = (pht_m[ui] == 0) ? 0 : pht_m[ui] - 1;
      ghr_m = ((ghr_m * 2) + int'(act)) & MASK;
      br_m  = br_m + 32'd1;
      if (pt != act) mis_m = mis_m + 32'd1;
    end
  endtask

  // One clock cycle: drive at the falling edge, check after the rising edge.
  task automatic do_cycle(input bit r, input logic [31:0] pc, input bit st, input bit fl,
                          input bit ue, input logic [31:0] up, input int ug,
                          input bit act, input bit pt);
    rst = r; pcF = pc; stallD = st; flushD = fl; update_en = ue;
    update_pc = up; update_ghr = IDX_W'(ug); actual_taken = act; pred_taken = pt;
    #1;
    check("mispredict", {31'd0, mispredict}, {31'd0, ue & (pt != act)});
    model_step(r, pc, st, fl, ue, up, ug, act, pt);
    @(posedge clk); #1;
    check("predict_takeD", {31'd0, predict_takeD}, {31'd0, pred_m});
    check("ghrD", 32'(ghrD), 32'(ghrd_m));
    check("br_cnt", br_cnt, br_m);
    check("mis_cnt", mis_cnt, mis_m);
    $display("cyc rst=%0b pc=%08h st=%0b fl=%0b ue=%0b upc=%08h ughr=%02h act=%0b pt=%0b -> pred=%0b ghrD=%02h br=%0d mis=%0d",
             r, pc, st, fl, ue, up, ug, act, pt, predict_takeD, ghrD, br_cnt, mis_cnt);
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] pc);
    do_cycle(0, pc, 0, 0, 0, 32'd0, 0, 0, 0);
  endtask

  bit held;

  initial begin
    @(negedge clk);
    do_cycle(1, 32'd0, 0, 0, 0, 32'd0, 0, 0, 0);
    check("reset_pred", {31'd0, predict_takeD}, 32'd0);

    // Fresh lookup after reset predicts not-taken with empty history.
    idle(32'h0040_0010);
    check("first_pred", {31'd0, predict_takeD}, 32'd0);
    check("first_ghrD", 32'(ghrD), 32'd0);

    // Two taken updates train entry 4 to strongly taken; ghr becomes 000011.
    do_cycle(0, 32'd0, 0, 0, 1, 32'h0040_0010, 0, 1, 0);
    do_cycle(0, 32'd0, 0, 0, 1, 32'h0040_0010, 0, 1, 0);
    idle(32'h0000_001C);            // index 7 ^ 3 = 4
    check("train_pred", {31'd0, predict_takeD}, 32'd1);
    check("train_ghr", 32'(ghrD), 32'd3);
    check("train_br_cnt", br_cnt, 32'd2);

    // Saturate high, then four not-taken updates drive the entry to 00.
    do_cycle(0, 32'd0, 0, 0, 1, 32'h0040_0010, 0, 1, 1);
    for (int i = 0; i < 4; i++) do_cycle(0, 32'd0, 0, 0, 1, 32'h0040_0010, 0, 0, 0);
    check("sat_low_model", 32'(pht_m[4]), 32'd0);
    do_cycle(0, 32'd0, 0, 0, 1, 32'h0040_0010, 0, 0, 0);

    // Read-before-write on a 01 entry.
    do_cycle(1, 32'd0, 0, 0, 0, 32'd0, 0, 0, 0);
    do_cycle(0, 32'h0000_0020, 0, 0, 1, 32'h0000_0020, 0, 1, 0);
    check("rbw_first", {31'd0, predict_takeD}, 32'd0);
    idle(32'h0000_0024);            // index 9 ^ 1 = 8
    check("rbw_second", {31'd0, predict_takeD}, 32'd1);

    // Stall holds the decode register across changing PCs.
    idle(32'h0000_0024);
    held = predict_takeD;
    for (int i = 0; i < 3; i++) do_cycle(0, $urandom, 1, 0, 0, 32'd0, 0, 0, 0);
    check("stall_hold", {31'd0, predict_takeD}, {31'd0, pred_m});
    check("stall_const", {31'd0, predict_takeD}, 32'd1);
    do_cycle(0, 32'h0000_0024, 1, 1, 0, 32'd0, 0, 0, 0);
    check("flush_over_stall", {31'd0, predict_takeD}, 32'd0);

    // Mispredict pulse and counter wrap through a forced preload.
    do_cycle(0, 32'd0, 0, 0, 1, 32'h0000_0100, 0, 0, 1);
    force dut.mis_cnt = 32'hFFFF_FFFF;
    mis_m = 32'hFFFF_FFFF;
    idle(32'd0);
    release dut.mis_cnt;
    do_cycle(0, 32'd0, 0, 0, 1, 32'h0000_0100, 0, 0, 1);
    check("mis_wrap", mis_cnt, 32'd0);

    // Random traffic; update PCs drawn from a small pool so entries collide often.
    for (int i = 0; i < 1500; i++) begin
      do_cycle($urandom_range(0, 99) == 0, $urandom, $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
               {$urandom_range(0, 3), 2'b00} << 2 | ($urandom & 32'hFFFF_FF00),
               int'($urandom_range(0, MASK)), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
